jr_hazard_fwd_unit: RTL

- Parametrised successor to the single-source jump forwarding unit.
- Resolves the register operand of a JR/JALR in ID, forwarding from the MEM stage (ALU result or link PC) or from WB, in fixed priority.
- Inserts counted stall cycles when the operand is not yet available: producer in EX, or load in EX/MEM.
- Sits beside the ID-stage hazard unit; drives the IF/ID freeze and the jump-target mux.

---
 rtl/jr_hazard_fwd_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/jr_hazard_fwd_unit.sv
// JR/JALR operand hazard and forwarding unit: resolves the jump register in ID via MEM/WB bypass
// and inserts counted stalls for producers still in flight. Optional macro: JR_HAZARD_STATS_EN.
module jr_hazard_fwd_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned STALL_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_jr_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [1:0]        ex_mem_to_reg,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [1:0]        mem_mem_to_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_link_pc,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall_if_id,
  output logic [1:0]        fwd_sel,
  output logic [DATA_W-1:0] jr_target,
  output logic              jr_target_valid,
  output logic              busy
`ifdef JR_HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam logic [1:0] SelAlu  = 2'b00;
  localparam logic [1:0] SelLoad = 2'b01;
  localparam logic [1:0] SelLink = 2'b10;

  localparam logic [1:0] FwdRf      = 2'b00;
  localparam logic [1:0] FwdMemAlu  = 2'b01;
  localparam logic [1:0] FwdMemLink = 2'b10;
  localparam logic [1:0] FwdWb      = 2'b11;

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  state_e             state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;
  logic [STALL_W-1:0] need;
  logic               rs_nz, ex_hit, mem_hit, wb_hit;

  // $0 is hardwired, so it never matches an in-flight producer.
  assign rs_nz   = |id_rs;
  assign ex_hit  = ex_reg_write  && (ex_rd  == id_rs) && rs_nz;
  assign mem_hit = mem_reg_write && (mem_rd == id_rs) && rs_nz;
  assign wb_hit  = wb_reg_write  && (wb_rd  == id_rs) && rs_nz;

  always_comb begin
    need = '0;
    if (ex_hit) begin
      need = (ex_mem_to_reg == SelLoad) ? STALL_W'(2) : STALL_W'(1);
    end else if (mem_hit && (mem_mem_to_reg == SelLoad)) begin
      need = STALL_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_if_id = 1'b0;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (id_jr_valid && (need != '0)) begin
            stall_if_id = 1'b1;
            cnt_d       = need - STALL_W'(1);
            if (need > STALL_W'(1)) begin
              state_d = StStall;
            end
          end
        end
        StStall: begin
          stall_if_id = 1'b1;
          if (cnt_q <= STALL_W'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - STALL_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StStall);

  always_comb begin
    fwd_sel   = FwdRf;
    jr_target = rf_rs_data;
    if (!stall_if_id) begin
      if (mem_hit && (mem_mem_to_reg == SelAlu)) begin
        fwd_sel   = FwdMemAlu;
        jr_target = mem_alu_result;
      end else if (mem_hit && (mem_mem_to_reg == SelLink)) begin
        fwd_sel   = FwdMemLink;
        jr_target = mem_link_pc;
      end else if (wb_hit) begin
        fwd_sel   = FwdWb;
        jr_target = wb_data;
      end
    end
  end

  assign jr_target_valid = id_jr_valid & ~stall_if_id & ~flush;

`ifdef JR_HAZARD_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_if_id && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
